// File: rtl/pipe_reg_stage.sv
// ---------------------------------------------------------------------------
// pipe_reg_stage
//   Chain of DEPTH pipeline registers carrying a valid bit, a payload and a
//   control field. Every stage can be held by a common stall or turned into
//   a bubble on its own by a per-stage flush bit. The outputs come straight
//   from the last stage, so there is no combinational path from input to
//   output.
//
//   Optional feature macro: PIPE_STATS_EN
//     When defined, adds saturating 16-bit stall and flush event counters.
//
// Parameters
//   DATA_W  payload width (result, read data, rd, pc+4)
//   CTRL_W  control width (reg_write, result_src[1:0])
//   DEPTH   number of chained stages, 1..4
//
// Ports
//   clk          sole clock, rising edge
//   rst_n        synchronous active-low reset
//   valid_i      stage-0 input carries a real instruction
//   data_i       payload into stage 0
//   ctrl_i       control into stage 0 (masked to zero when valid_i=0)
//   stall_i      hold every stage that is not being flushed
//   flush_i      per-stage bubble request, bit k targets stage k
//   valid_o      last-stage valid
//   data_o       last-stage payload
//   ctrl_o       last-stage control, zero whenever valid_o=0
//   occ_o        number of valid stages
//   stall_cnt_o  (PIPE_STATS_EN) edges stalled with a non-empty pipe
//   flush_cnt_o  (PIPE_STATS_EN) valid stages killed by flush
// ---------------------------------------------------------------------------
module pipe_reg_stage #(
  parameter int DATA_W = 101,
  parameter int CTRL_W = 3,
  parameter int DEPTH  = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         valid_i,
  input  logic [DATA_W-1:0]            data_i,
  input  logic [CTRL_W-1:0]            ctrl_i,
  input  logic                         stall_i,
  input  logic [DEPTH-1:0]             flush_i,
  output logic                         valid_o,
  output logic [DATA_W-1:0]            data_o,
  output logic [CTRL_W-1:0]            ctrl_o,
  output logic [$clog2(DEPTH+1)-1:0]   occ_o
`ifdef PIPE_STATS_EN
  ,
  output logic [15:0]                  stall_cnt_o,
  output logic [15:0]                  flush_cnt_o
`endif
);

  localparam int OCC_W = $clog2(DEPTH+1);

  // Stage state
  logic [DEPTH-1:0]             r_valid;
  logic [DEPTH-1:0][DATA_W-1:0] r_data;
  logic [DEPTH-1:0][CTRL_W-1:0] r_ctrl;

  // What each stage loads when it advances
  logic [DEPTH-1:0]             w_src_valid;
  logic [DEPTH-1:0][DATA_W-1:0] w_src_data;
  logic [DEPTH-1:0][CTRL_W-1:0] w_src_ctrl;

  logic [OCC_W-1:0]             w_occ;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_src
      if (gi == 0) begin : g_head
        // Masking here keeps the invariant that an invalid stage has zero
        // control, so a bubble can never raise reg_write downstream.
        assign w_src_valid[gi] = valid_i;
        assign w_src_data[gi]  = data_i;
        assign w_src_ctrl[gi]  = ctrl_i & {CTRL_W{valid_i}};
      end else begin : g_body
        assign w_src_valid[gi] = r_valid[gi-1];
        assign w_src_data[gi]  = r_data[gi-1];
        assign w_src_ctrl[gi]  = r_ctrl[gi-1];
      end
    end
  endgenerate

  // Flush beats stall on a per-stage basis; data of a flushed stage is left
  // as is since nothing downstream looks at it once valid is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_data  <= '0;
      r_ctrl  <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (flush_i[k]) begin
          r_valid[k] <= 1'b0;
          r_ctrl[k]  <= '0;
        end else if (!stall_i) begin
          r_valid[k] <= w_src_valid[k];
          r_data[k]  <= w_src_data[k];
          r_ctrl[k]  <= w_src_ctrl[k];
        end
      end
    end
  end

  always_comb begin
    w_occ = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_occ = w_occ + OCC_W'(r_valid[k]);
    end
  end

  assign valid_o = r_valid[DEPTH-1];
  assign data_o  = r_data[DEPTH-1];
  assign ctrl_o  = r_ctrl[DEPTH-1];
  assign occ_o   = w_occ;

`ifdef PIPE_STATS_EN
  logic [15:0]      r_stall_cnt;
  logic [15:0]      r_flush_cnt;
  logic [OCC_W-1:0] w_kill_cnt;
  logic [16:0]      w_flush_sum;

  // Stages killed this edge: valid before the edge and targeted by flush.
  always_comb begin
    w_kill_cnt = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_kill_cnt = w_kill_cnt + OCC_W'(r_valid[k] & flush_i[k]);
    end
  end

  assign w_flush_sum = {1'b0, r_flush_cnt} + 17'(w_kill_cnt);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (stall_i && (w_occ != '0) && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
      // A multi-stage kill can jump past the top, so clamp on the carry.
      r_flush_cnt <= w_flush_sum[16] ? 16'hFFFF : w_flush_sum[15:0];
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;
`else
  // Statistics counters are not built; the pipeline above is unchanged.
`endif

endmodule
